// File: rtl/timx_pwm_pkg.sv
// Shared register map, field positions and helpers for the timx_pwm_core_n advanced-timer PWM slice.
package timx_pwm_pkg;

  localparam logic [7:0] ADDR_CR1  = 8'h00;
  localparam logic [7:0] ADDR_DIER = 8'h0C;
  localparam logic [7:0] ADDR_SR   = 8'h10;
  localparam logic [7:0] ADDR_EGR  = 8'h14;
  localparam logic [7:0] ADDR_CCER = 8'h20;
  localparam logic [7:0] ADDR_PSC  = 8'h28;
  localparam logic [7:0] ADDR_ARR  = 8'h2C;
  localparam logic [7:0] ADDR_CCR0 = 8'h34;
  localparam logic [7:0] ADDR_BDTR = 8'h44;

  localparam int CR1_CEN   = 0;
  localparam int CR1_CMS   = 5;
  localparam int CR1_ARPE  = 7;
  localparam int DIER_UIE  = 0;
  localparam int SR_UIF    = 0;
  localparam int EGR_UG    = 0;
  localparam int BDTR_BKE  = 12;
  localparam int BDTR_BKP  = 13;
  localparam int BDTR_MOE  = 15;

  // CCER packs four control bits per channel starting at bit 4n.
  localparam int CCER_E  = 0;
  localparam int CCER_P  = 1;
  localparam int CCER_NE = 2;
  localparam int CCER_NP = 3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  function automatic logic [7:0] ccr_addr(input int n);
    return ADDR_CCR0 + 8'(4 * n);
  endfunction

endpackage

// File: rtl/timx_dtg_cell.sv
// Per-channel output stage: turns the PWM reference into main/complementary drive with optional
// dead time (TIMX_DEADTIME_EN); without the macro it is a plain pass-through.
module timx_dtg_cell #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DT_W-1:0] dtg,
  input  logic            ref_in,
  output logic            oc,
  output logic            ocn
);

`ifdef TIMX_DEADTIME_EN
  logic            ref_prev;
  logic [DT_W-1:0] age;
  logic [DT_W-1:0] run;

  // run = cycles the reference has held its present level, saturating; 0 on the edge cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    run = '0;
    if (ref_in == ref_prev) begin
      run = (age == '1) ? age : age + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_prev <= 1'b0;
      age      <= '0;
    end else begin
      ref_prev <= ref_in;
      age      <= run;
    end
  end

  // Rising edges wait until the level has been stable for dtg cycles; falls are immediate.
  assign oc  = ref_in  & (run >= dtg);
  assign ocn = ~ref_in & (run >= dtg);
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, dtg};
  assign oc        = ref_in;
  assign ocn       = ~ref_in;
`endif

endmodule

// File: rtl/timx_pwm_core_n.sv
// Advanced-timer PWM core: APB registers, prescaled up/centre counter, PWM mode 1, break.
// Optional dead-time insertion is built when TIMX_DEADTIME_EN is defined.
module timx_pwm_core_n
  import timx_pwm_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int PSC_W = 16,
  parameter int DT_W  = 8
) (
  input  logic           apb_clk,
  input  logic           apb_rst,
  input  logic           timx_psel,
  input  logic           timx_penable,
  input  logic           timx_pwrite,
  input  logic [7:0]     timx_paddr,
  input  logic [31:0]    timx_pwdata,
  output logic [31:0]    timx_prdata,
  input  logic           timx_dbg_stop,
  input  logic           timx_bkin,
  output logic [NCH-1:0] timx_ch_out,
  output logic [NCH-1:0] timx_ch_out_en,
  output logic [NCH-1:0] timx_chn_out,
  output logic [NCH-1:0] timx_chn_out_en,
  output logic           timx_int_ud,
  output logic [NCH-1:0] timx_int_cc,
  output logic           timx_trgo
);

  // Programmer-visible registers
  logic             cen, cms, arpe;
  logic             uie;
  logic [NCH-1:0]   ccie;
  logic             uif;
  logic [NCH-1:0]   ccif;
  logic [NCH-1:0]   cc_e, cc_p, cc_ne, cc_np;
  logic [PSC_W-1:0] psc_pre;
  logic [CNT_W-1:0] arr_pre;
  logic [CNT_W-1:0] ccr_pre [NCH];
  logic             bke, bkp, moe;
  logic [DT_W-1:0]  dtg_eff;

  // Counting state and active (shadow) copies
  logic [PSC_W-1:0] psc_cnt, psc_sh;
  logic [CNT_W-1:0] cnt, cnt_nxt, arr_sh;
  logic [CNT_W-1:0] ccr_sh [NCH];
  cnt_dir_e         dir, dir_nxt;
  logic [NCH-1:0]   ref_q;
  logic             trgo_q;

  logic wr_en, wr_cr1, wr_dier, wr_sr, wr_ccer, wr_psc, wr_arr, wr_bdtr;
  logic ug, tick, uev_cnt, uev, brk;
  logic [NCH-1:0] cc_hit, oc, ocn;
  logic [31:0] rd;
  logic unused_bits;

  assign wr_en   = timx_psel & timx_penable & timx_pwrite;
  assign wr_cr1  = wr_en && (timx_paddr == ADDR_CR1);
  assign wr_dier = wr_en && (timx_paddr == ADDR_DIER);
  assign wr_sr   = wr_en && (timx_paddr == ADDR_SR);
  assign wr_ccer = wr_en && (timx_paddr == ADDR_CCER);
  assign wr_psc  = wr_en && (timx_paddr == ADDR_PSC);
  assign wr_arr  = wr_en && (timx_paddr == ADDR_ARR);
  assign wr_bdtr = wr_en && (timx_paddr == ADDR_BDTR);
  assign ug      = wr_en && (timx_paddr == ADDR_EGR) && timx_pwdata[EGR_UG];

  assign tick = cen & ~timx_dbg_stop & (psc_cnt == psc_sh);
  assign brk  = bke & (timx_bkin ^ bkp);
  assign uev  = uev_cnt | ug;

  assign unused_bits = ^{timx_pwdata, timx_paddr};

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    uev_cnt = 1'b0;
    if (tick) begin
      if (!cms || (arr_sh == '0)) begin
        dir_nxt = DIR_UP;
        if (cnt >= arr_sh) begin
          cnt_nxt = '0;
          uev_cnt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (dir == DIR_UP) begin
        if (cnt >= arr_sh) begin
          cnt_nxt = cnt - 1'b1;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        // Centre-aligned underflow: the only update point, then turn round.
        if (cnt == '0) begin
          cnt_nxt = CNT_W'(1);
          dir_nxt = DIR_UP;
          uev_cnt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      cc_hit[n] = tick & (cnt == ccr_sh[n]);
    end
  end

  // Software-written registers
  always_ff @(posedge apb_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (apb_rst) begin
      cen     <= 1'b0;
      cms     <= 1'b0;
      arpe    <= 1'b0;
      uie     <= 1'b0;
      ccie    <= '0;
      cc_e    <= '0;
      cc_p    <= '0;
      cc_ne   <= '0;
      cc_np   <= '0;
      psc_pre <= '0;
      arr_pre <= '0;
      bke     <= 1'b0;
      bkp     <= 1'b0;
      moe     <= 1'b0;
      // NOTE: the CCR array is a handful of flops, not RAM, so it is reset like any other register.
      for (int n = 0; n < NCH; n++) ccr_pre[n] <= '0;
    end else begin
      if (wr_cr1) begin
        cen  <= timx_pwdata[CR1_CEN];
        cms  <= timx_pwdata[CR1_CMS];
        arpe <= timx_pwdata[CR1_ARPE];
      end
      if (wr_dier) begin
        uie  <= timx_pwdata[DIER_UIE];
        ccie <= timx_pwdata[NCH:1];
      end
      if (wr_ccer) begin
        for (int n = 0; n < NCH; n++) begin
          cc_e[n]  <= timx_pwdata[4*n+CCER_E];
          cc_p[n]  <= timx_pwdata[4*n+CCER_P];
          cc_ne[n] <= timx_pwdata[4*n+CCER_NE];
          cc_np[n] <= timx_pwdata[4*n+CCER_NP];
        end
      end
      if (wr_psc) psc_pre <= timx_pwdata[PSC_W-1:0];
      if (wr_arr) arr_pre <= timx_pwdata[CNT_W-1:0];
      for (int n = 0; n < NCH; n++) begin
        if (wr_en && (timx_paddr == ccr_addr(n))) ccr_pre[n] <= timx_pwdata[CNT_W-1:0];
      end
      if (wr_bdtr) begin
        bke <= timx_pwdata[BDTR_BKE];
        bkp <= timx_pwdata[BDTR_BKP];
      end
      // Break beats a simultaneous MOE write; only software can set MOE again.
      if (brk)          moe <= 1'b0;
      else if (wr_bdtr) moe <= timx_pwdata[BDTR_MOE];
    end
  end

`ifdef TIMX_DEADTIME_EN
  logic [DT_W-1:0] dtg_q;
  always_ff @(posedge apb_clk) begin
    if (apb_rst)      dtg_q <= '0;
    else if (wr_bdtr) dtg_q <= timx_pwdata[DT_W-1:0];
  end
  assign dtg_eff = dtg_q;
`else
  assign dtg_eff = '0;
`endif

  // Counter, shadows, flags and the registered PWM reference
  always_ff @(posedge apb_clk) begin
    if (apb_rst) begin
      psc_cnt <= '0;
      psc_sh  <= '0;
      cnt     <= '0;
      dir     <= DIR_UP;
      arr_sh  <= '0;
      uif     <= 1'b0;
      ccif    <= '0;
      ref_q   <= '0;
      trgo_q  <= 1'b0;
      for (int n = 0; n < NCH; n++) ccr_sh[n] <= '0;
    end else begin
      if (ug) begin
        psc_cnt <= '0;
        cnt     <= '0;
        dir     <= DIR_UP;
      end else begin
        if (cen && !timx_dbg_stop) psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
      if (uev) begin
        psc_sh <= psc_pre;
        for (int n = 0; n < NCH; n++) ccr_sh[n] <= ccr_pre[n];
        if (arpe) arr_sh <= arr_pre;
      end
      if (wr_arr && !arpe) arr_sh <= timx_pwdata[CNT_W-1:0];
      // Writing 0 clears a flag, 1 leaves it; a same-cycle hardware set wins.
      uif <= (uif & ~(wr_sr & ~timx_pwdata[SR_UIF])) | uev;
      for (int n = 0; n < NCH; n++) begin
        ccif[n]  <= (ccif[n] & ~(wr_sr & ~timx_pwdata[n+1])) | cc_hit[n];
        ref_q[n] <= (cnt < ccr_sh[n]);
      end
      trgo_q <= uev;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timx_dtg_cell #(.DT_W(DT_W)) u_dtg (
      .clk    (apb_clk),
      .rst    (apb_rst),
      .dtg    (dtg_eff),
      .ref_in (ref_q[g]),
      .oc     (oc[g]),
      .ocn    (ocn[g])
    );
  end

  assign timx_ch_out     = {NCH{moe}} & (oc ^ cc_p);
  assign timx_chn_out    = {NCH{moe}} & (ocn ^ cc_np);
  assign timx_ch_out_en  = {NCH{moe}} & cc_e;
  assign timx_chn_out_en = {NCH{moe}} & cc_ne;
  assign timx_int_ud     = uif & uie;
  assign timx_int_cc     = ccif & ccie;
  assign timx_trgo       = trgo_q;

  always_comb begin
    rd = '0;
    case (timx_paddr)
      ADDR_CR1: begin
        rd[CR1_CEN]  = cen;
        rd[CR1_CMS]  = cms;
        rd[CR1_ARPE] = arpe;
      end
      ADDR_DIER: begin
        rd[DIER_UIE] = uie;
        for (int n = 0; n < NCH; n++) rd[n+1] = ccie[n];
      end
      ADDR_SR: begin
        rd[SR_UIF] = uif;
        for (int n = 0; n < NCH; n++) rd[n+1] = ccif[n];
      end
      ADDR_CCER: begin
        for (int n = 0; n < NCH; n++) begin
          rd[4*n+CCER_E]  = cc_e[n];
          rd[4*n+CCER_P]  = cc_p[n];
          rd[4*n+CCER_NE] = cc_ne[n];
          rd[4*n+CCER_NP] = cc_np[n];
        end
      end
      ADDR_PSC: rd[PSC_W-1:0] = psc_pre;
      ADDR_ARR: rd[CNT_W-1:0] = arr_pre;
      ADDR_BDTR: begin
        rd[DT_W-1:0] = dtg_eff;
        rd[BDTR_BKE] = bke;
        rd[BDTR_BKP] = bkp;
        rd[BDTR_MOE] = moe;
      end
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (timx_paddr == ccr_addr(n)) rd[CNT_W-1:0] = ccr_pre[n];
        end
      end
    endcase
  end

  assign timx_prdata = (timx_psel && !timx_pwrite) ? rd : '0;

endmodule
